uart_rx_os: RTL
===============

Name: uart_rx_os

Overview:
Parametrised, oversampling UART receiver, the next generation of the team's fixed-format receive path. Frame format is selected at run time: data bits, parity mode, stop bits and bit order. Each bit is recovered by a 3-sample majority vote at mid-bit. Received words leave on a valid/ready handshake towards the receive FIFO, together with break, parity, framing and overrun status. RTS flow control is generated locally.

Parameters:
SYSCLK_RATE, 100000000, system clock frequency in Hz
BAUD_RATE, 9600, line bit rate in Hz
OVERSAMPLE, 16, sample ticks per bit; even, ≥8
MAX_DATA_BITS, 9, width of Data_Out; run-time data length is 5..MAX_DATA_BITS
DIV (local), SYSCLK_RATE/(BAUD_RATE*OVERSAMPLE), integer-truncated; elaboration error if < 1

Ports:
Clk  in  1  system clock; the only clock
Rst_n  in  1  synchronous, active-low reset
Rx  in  1  asynchronous serial line; idle high
Cfg_Data_Bits  in  4  data bits per frame, 5..MAX_DATA_BITS; out-of-range values clamp to the nearest limit
Cfg_Parity  in  2  00 none, 01 even, 10 odd, 11 space (parity bit must be 0)
Cfg_Stop2  in  1  0 = one stop bit, 1 = two stop bits
Cfg_Lsb_First  in  1  0 = MSB first (team legacy format), 1 = LSB first
Data_Out  out  MAX_DATA_BITS  received word, right-justified, upper bits zero
Data_Valid  out  1  Data_Out and Rx_Error are valid
Data_Ready  in  1  consumer accepts the word
Rx_Error  out  3  [0] break, [1] parity, [2] frame; qualified by Data_Valid
Overrun  out  1  sticky; a frame was dropped
Overrun_Clr  in  1  clears Overrun
RTS  out  1  high = ready to receive
Rx_Busy  out  1  high outside IDLE

Behaviour:
- Reset (Rst_n low at a Clk edge): state IDLE. Data_Out=0, Data_Valid=0, Rx_Error=0, Overrun=0, RTS=1, Rx_Busy=0. Synchroniser flops and majority register preset to 1. Tick divider cleared.
- Reset mid-frame: the partial frame is discarded and no Data_Valid is produced.
- Rx passes through a 2-flop synchroniser; all sampling uses the synchronised signal, so there is 2 Clk of latency.
- Tick: a 1-Clk pulse every DIV clocks. A per-bit sample counter runs 0..OVERSAMPLE-1.
- Majority vote: samples taken at counter values OS/2-1, OS/2 and OS/2+1; the bit value is the majority of the three.
- Configuration is latched on the IDLE→START transition. Changes mid-frame have no effect until the next frame.
- IDLE: on a high→low transition of synchronised Rx, restart the divider and sample counter, then go to START.
- START: at mid-bit, a voted 1 is a false start → IDLE with no output. A voted 0 → DATA.
- DATA: shift Cfg_Data_Bits bits, placed MSB-first or LSB-first per the latched order. Then go to PARITY if parity is enabled, otherwise to STOP.
- PARITY: even → data XOR parity bit must be 0. Odd → must be 1. Space → parity bit must be 0. A mismatch sets the pending parity error.
- STOP: sample 1 or 2 stop bits. Any stop bit voted 0 sets the pending frame error.
- Break: all data bits, the parity bit (if enabled) and the first stop bit are voted 0.
  - Report Rx_Error=3'b001 only; parity and frame errors are suppressed.
  - Data_Out=0.
  - Go to BREAK_WAIT.
- BREAK_WAIT: remain until synchronised Rx has been high for one full bit time (OVERSAMPLE ticks), then go to IDLE.
- Frame completion: at mid-point of the last stop bit, register the word and errors.
  - If Data_Valid=0, set Data_Valid=1 on the next Clk.
  - If Data_Valid=1 and not accepted in the same cycle, drop the new frame, keep the old one and set Overrun.
- After the last stop-bit sample, return to IDLE immediately. A new start edge can be detected from the second half of the stop bit onward.
- Handshake: Data_Valid=1 and Data_Ready=1 clears Data_Valid and Rx_Error on the next Clk. Data_Out holds its value until the next word.
- Simultaneous accept and completion: the new word loads with Data_Valid=1, and there is no overrun.
- Overrun stays set until Overrun_Clr=1. If Overrun_Clr and a new overrun occur in the same cycle, Overrun stays 1.
- RTS = !(Data_Valid && !Data_Ready) && state != BREAK_WAIT, registered (one Clk of latency).
- Rx_Busy = (state != IDLE).

Decomposition:
- Package uart_pkg:
  - parity_e (PAR_NONE, PAR_EVEN, PAR_ODD, PAR_SPACE)
  - rx_state_e (IDLE, START, DATA, PARITY, STOP, BREAK_WAIT)
  - localparams ERR_BREAK=0, ERR_PARITY=1, ERR_FRAME=2
- One sub-module, uart_baud_tick: divider with a synchronous restart input, emitting the 1-Clk tick; parameterised by DIV.
- Synchroniser, majority vote, FSM and output register stay in uart_rx_os.

Test Plan:
Simulation uses SYSCLK_RATE=1600000, BAUD_RATE=10000, OVERSAMPLE=16, so DIV=10 and one bit = 160 Clk.
1. 8 data bits, even parity, 2 stop bits, MSB-first; send 0xA5 with parity 0 → Data_Out=0x0A5, Rx_Error=000, Data_Valid within 2 Clk of the mid-point of the last stop bit.
2. Same frame with the parity bit inverted → Data_Out=0x0A5, Rx_Error=010. Then set stop bits to 0 with the correct parity → Rx_Error=100.
3. Line held low for 15 bit times → a single word with Rx_Error=001 and Data_Out=0. Rx_Busy stays high until Rx has been high for 160 Clk. No second word is produced.
4. 9 data bits, odd parity, 1 stop bit, LSB-first; send 0x1C3 → Data_Out=0x1C3. Glitch one sample per bit (at OS/2+1) → still 0x1C3 with no error. A 3-tick low pulse on an idle line → no output.
5. Data_Ready=0; send 0x11 then 0x22 → Data_Out stays 0x11, Overrun=1, RTS=0. Pulse Data_Ready → Data_Valid=0 and RTS=1. Pulse Overrun_Clr → Overrun=0.
6. Assert Rst_n low for 1 Clk during data bit 4 → all outputs return to reset values, no word is produced, and the next clean 0x3C frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE  = 2'b00,
        PAR_EVEN  = 2'b01,
        PAR_ODD   = 2'b10,
        PAR_SPACE = 2'b11
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK_WAIT
    } rx_state_e;

    localparam int unsigned ERR_BREAK  = 0;
    localparam int unsigned ERR_PARITY = 1;
    localparam int unsigned ERR_FRAME  = 2;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-Clk pulse every DIV clocks, phase-restartable.
module uart_baud_tick #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] count;

    // Divider counts 0..DIV-1; restart realigns the phase to the start edge.
    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            count <= '0;
        end else if (count == CW'(DIV - 1)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == '0);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with run-time frame format and valid/ready output.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int unsigned SYSCLK_RATE   = 100000000,
    parameter int unsigned BAUD_RATE     = 9600,
    parameter int unsigned OVERSAMPLE    = 16,
    parameter int unsigned MAX_DATA_BITS = 9
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     Rx,
    input  logic [3:0]               Cfg_Data_Bits,
    input  logic [1:0]               Cfg_Parity,
    input  logic                     Cfg_Stop2,
    input  logic                     Cfg_Lsb_First,
    output logic [MAX_DATA_BITS-1:0] Data_Out,
    output logic                     Data_Valid,
    input  logic                     Data_Ready,
    output logic [2:0]               Rx_Error,
    output logic                     Overrun,
    input  logic                     Overrun_Clr,
    output logic                     RTS,
    output logic                     Rx_Busy
);

    localparam int unsigned DIV = SYSCLK_RATE / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned OSW = $clog2(OVERSAMPLE);
    localparam int unsigned IW  = $clog2(MAX_DATA_BITS);

    if (DIV < 1) begin : g_bad_div
        $error("uart_rx_os: SYSCLK_RATE/(BAUD_RATE*OVERSAMPLE) must be at least 1");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
        $error("uart_rx_os: OVERSAMPLE must be even and at least 8");
    end
    if (MAX_DATA_BITS < 5 || MAX_DATA_BITS > 15) begin : g_bad_width
        $error("uart_rx_os: MAX_DATA_BITS must be within 5..15");
    end

    logic                     sync1, sync2, rx_prev, rx_s;
    logic                     edge_fall, restart, tick, dec, vote;
    logic [1:0]               samp;
    logic [OSW-1:0]           os_cnt;
    rx_state_e                state, state_nx;
    logic [3:0]               cfg_bits_cl, nbits, bit_idx;
    parity_e                  par_mode;
    logic                     stop2, lsb_first, stop_idx;
    logic                     par_acc, par_err, frm_err, all_zero;
    logic [MAX_DATA_BITS-1:0] shreg, word_nx;
    logic [2:0]               err_nx;
    logic [IW-1:0]            pos;
    logic                     done, brk;

    assign rx_s      = sync2;
    assign edge_fall = rx_prev & ~rx_s;
    assign restart   = (state == IDLE) && edge_fall;
    assign dec       = tick && (os_cnt == OSW'(OVERSAMPLE / 2 + 1));
    assign vote      = maj3(samp[1], samp[0], rx_s);
    assign pos       = lsb_first ? IW'(bit_idx) : IW'(nbits - 4'd1 - bit_idx);
    assign Rx_Busy   = (state != IDLE);

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk     (Clk),
        .rst_n   (Rst_n),
        .restart (restart),
        .tick    (tick)
    );

    // Clamp the requested data length into the supported range.
    always_comb begin
        cfg_bits_cl = Cfg_Data_Bits;
        if (Cfg_Data_Bits < 4'd5) begin
            cfg_bits_cl = 4'd5;
        end else if (Cfg_Data_Bits > 4'(MAX_DATA_BITS)) begin
            cfg_bits_cl = 4'(MAX_DATA_BITS);
        end
    end

    // Next-state decode plus the completed word and its error flags.
    always_comb begin
        state_nx = state;
        done     = 1'b0;
        brk      = 1'b0;
        word_nx  = shreg;
        err_nx   = '0;
        unique case (state)
            IDLE:   if (edge_fall) state_nx = START;
            START:  if (dec) state_nx = vote ? IDLE : DATA;
            DATA:   if (dec && bit_idx == nbits - 4'd1)
                        state_nx = (par_mode == PAR_NONE) ? STOP : PARITY;
            PARITY: if (dec) state_nx = STOP;
            STOP: begin
                if (dec) begin
                    if (!stop_idx && all_zero && !vote) begin
                        done     = 1'b1;
                        brk      = 1'b1;
                        state_nx = BREAK_WAIT;
                    end else if (stop_idx == stop2) begin
                        done     = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            BREAK_WAIT: if (tick && rx_s && os_cnt == OSW'(OVERSAMPLE - 1)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (brk) begin
            word_nx           = '0;
            err_nx[ERR_BREAK] = 1'b1;
        end else begin
            err_nx[ERR_PARITY] = par_err;
            err_nx[ERR_FRAME]  = frm_err | ~vote;
        end
    end

    // Synchroniser, sample counter, mid-bit samples and frame accumulation.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            rx_prev   <= 1'b1;
            samp      <= '1;
            os_cnt    <= '0;
            state     <= IDLE;
            nbits     <= 4'd8;
            par_mode  <= PAR_NONE;
            stop2     <= 1'b0;
            lsb_first <= 1'b0;
            bit_idx   <= '0;
            shreg     <= '0;
            par_acc   <= 1'b0;
            par_err   <= 1'b0;
            frm_err   <= 1'b0;
            all_zero  <= 1'b1;
            stop_idx  <= 1'b0;
        end else begin
            sync1   <= Rx;
            sync2   <= sync1;
            rx_prev <= sync2;
            state   <= state_nx;
            if (restart) begin
                os_cnt    <= '0;
                nbits     <= cfg_bits_cl;
                par_mode  <= parity_e'(Cfg_Parity);
                stop2     <= Cfg_Stop2;
                lsb_first <= Cfg_Lsb_First;
                bit_idx   <= '0;
                shreg     <= '0;
                par_acc   <= 1'b0;
                par_err   <= 1'b0;
                frm_err   <= 1'b0;
                all_zero  <= 1'b1;
                stop_idx  <= 1'b0;
            end else if (state == BREAK_WAIT) begin
                if (tick) os_cnt <= rx_s ? os_cnt + 1'b1 : '0;
            end else if (tick) begin
                os_cnt <= (os_cnt == OSW'(OVERSAMPLE - 1)) ? '0 : os_cnt + 1'b1;
                if (os_cnt == OSW'(OVERSAMPLE / 2 - 1)) samp[1] <= rx_s;
                if (os_cnt == OSW'(OVERSAMPLE / 2))     samp[0] <= rx_s;
            end
            if (dec) begin
                unique case (state)
                    DATA: begin
                        shreg[pos] <= vote;
                        par_acc    <= par_acc ^ vote;
                        all_zero   <= all_zero & ~vote;
                        bit_idx    <= bit_idx + 4'd1;
                    end
                    PARITY: begin
                        all_zero <= all_zero & ~vote;
                        unique case (par_mode)
                            PAR_EVEN:  par_err <= par_acc ^ vote;
                            PAR_ODD:   par_err <= ~(par_acc ^ vote);
                            PAR_SPACE: par_err <= vote;
                            default:   par_err <= 1'b0;
                        endcase
                    end
                    STOP: begin
                        frm_err  <= frm_err | ~vote;
                        stop_idx <= 1'b1;
                    end
                    default: ;
                endcase
            end
            // Break hold-off counts high ticks from zero, overriding the bit-phase count.
            if (brk) os_cnt <= '0;
        end
    end

    // Output word register, handshake, sticky overrun and registered RTS.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            Data_Out   <= '0;
            Data_Valid <= 1'b0;
            Rx_Error   <= '0;
            Overrun    <= 1'b0;
            RTS        <= 1'b1;
        end else begin
            RTS <= !(Data_Valid && !Data_Ready) && (state != BREAK_WAIT);
            if (done && (!Data_Valid || Data_Ready)) begin
                Data_Out   <= word_nx;
                Rx_Error   <= err_nx;
                Data_Valid <= 1'b1;
            end else if (Data_Valid && Data_Ready) begin
                Data_Valid <= 1'b0;
                Rx_Error   <= '0;
            end
            if (done && Data_Valid && !Data_Ready) begin
                Overrun <= 1'b1;
            end else if (Overrun_Clr) begin
                Overrun <= 1'b0;
            end
        end
    end

endmodule
